// File: rtl/one_hot_to_bin_dec.sv
// Registered one-hot to binary decoder with valid/ready handshake on both sides.
// Illegal codes (zero-hot or multi-hot) are flagged per result and tallied in a saturating counter.
module one_hot_to_bin_dec #(
  parameter int ONE_HOT_W = 16,
  parameter int BIN_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ONE_HOT_W-1:0] one_hot_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIN_W-1:0]     bin_out,
  output logic                 err_out,
  output logic [ERR_CNT_W-1:0] err_cnt,
  input  logic                 clr_err
);

  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic                 out_valid_q, out_valid_d;
  logic [BIN_W-1:0]     bin_q, bin_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  logic                 accept;
  logic                 retire;
  logic [BIN_W-1:0]     dec_idx;
  logic                 any_hot;
  logic                 multi_hot;
  logic                 illegal;
  logic [ERR_CNT_W-1:0] cnt_base;

  // The single output register frees itself whenever the consumer takes the result.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid_q && out_ready;

  // Lowest set bit wins, which is what a multi-hot code must report.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_idx = '0;
    any_hot = 1'b0;
    for (int i = 0; i < ONE_HOT_W; i++) begin
      if (!any_hot && one_hot_in[i]) begin
        dec_idx = BIN_W'(i);
        any_hot = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something behind only if two or more were set.
  assign multi_hot = |(one_hot_in & (one_hot_in - ONE_HOT_W'(1)));
  assign illegal   = !any_hot || multi_hot;

  always_comb begin
    out_valid_d = out_valid_q;
    bin_d       = bin_q;
    err_d       = err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      bin_d       = dec_idx;
      err_d       = illegal;
    end else if (retire) begin
      out_valid_d = 1'b0;
    end
  end

  // Clear takes effect first, so a same-cycle illegal code lands on a count of one.
  always_comb begin
    cnt_base = clr_err ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (accept && illegal && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      bin_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      out_valid_q <= out_valid_d;
      bin_q       <= bin_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bin_out   = bin_q;
  assign err_out   = err_q;
  assign err_cnt   = cnt_q;

endmodule
